// File: rtl/lib_pkg.sv
// lib_pkg: shared helpers for the lib_* blocks (modulo increment, one-hot encode).
package lib_pkg;
  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned m);
    return (v == m - 1) ? 0 : v + 1;
  endfunction
  // Bits are ORed together, so the result is only meaningful for one-hot inputs.
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) r = oh[i] ? (r | i) : r;
    return r;
  endfunction
endpackage

// File: rtl/lib_tag_fifo.sv
// lib_tag_fifo: in-order tag queue with wrap-bit full/empty, any DEPTH >= 2.
module lib_tag_fifo
  import lib_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic wwrap_q, wwrap_d, rwrap_q, rwrap_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok, pop_ok;
  always_comb begin
    full = (wptr_q == rptr_q) && (wwrap_q != rwrap_q);
    empty = (wptr_q == rptr_q) && (wwrap_q == rwrap_q);
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wptr_d = push_ok ? PW'(mod_inc(int'(wptr_q), DEPTH)) : wptr_q;
    wwrap_d = wwrap_q ^ (push_ok && wptr_q == PW'(DEPTH - 1));
    rptr_d = pop_ok ? PW'(mod_inc(int'(rptr_q), DEPTH)) : rptr_q;
    rwrap_d = rwrap_q ^ (pop_ok && rptr_q == PW'(DEPTH - 1));
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    dout = mem_q[rptr_q];
    count = count_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wwrap_q <= 1'b0;
      rwrap_q <= 1'b0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wwrap_q <= wwrap_d;
      rwrap_q <= rwrap_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/lib_rsp_router.sv
// lib_rsp_router: steers an in-order shared response stream back to the requester
// that owns the oldest outstanding grant.
module lib_rsp_router
  import lib_pkg::*;
#(
  parameter int NUM = 4,
  parameter int NUM_BITS = 32,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(NUM),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_fire,
  input  logic [NUM-1:0]          req_gnt,
  output logic                    tag_rdy,
  output logic                    err_gnt,
  input  logic                    rsp_val,
  input  logic [NUM_BITS-1:0]     rsp_d,
  output logic                    rsp_rdy,
  output logic [NUM-1:0]          out_val,
  output logic [NUM*NUM_BITS-1:0] out_d,
  input  logic [NUM-1:0]          out_rdy,
  output logic                    orphan,
  output logic [CW-1:0]           outstanding
);
  logic gnt_ok, push, pop, full, empty, err_gnt_q, err_gnt_d;
  logic [IW-1:0] gnt_idx, head;
  lib_tag_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .din(gnt_idx), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(outstanding)
  );
  // tag_rdy depends only on registered state, so no ready-to-ready loop upstream.
  always_comb begin
    gnt_ok = $onehot(req_gnt);
    gnt_idx = IW'(oh2idx(32'(req_gnt)));
    tag_rdy = !full;
    push = req_fire && tag_rdy && gnt_ok;
    err_gnt_d = req_fire && !gnt_ok;
    rsp_rdy = !empty && out_rdy[head];
    pop = rsp_val && rsp_rdy;
    orphan = rsp_val && empty;
    out_d = {NUM{rsp_d}};
    for (int i = 0; i < NUM; i++) out_val[i] = rsp_val && !empty && head == IW'(i);
    err_gnt = err_gnt_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_gnt_q <= 1'b0;
    else err_gnt_q <= err_gnt_d;
  end
endmodule

// File: tb/tb_lib_rsp_router.sv
// tb_lib_rsp_router: scoreboard bench; granted lanes queue up and are checked as responses fire.
module tb_lib_rsp_router;
  localparam int NUM = 4, NB = 32, DEPTH = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic req_fire = 1'b0, rsp_val = 1'b0, tag_rdy, err_gnt, rsp_rdy, orphan;
  logic [NUM-1:0] req_gnt = '0, out_val, out_rdy = '0;
  logic [NB-1:0] rsp_d = '0;
  logic [NUM*NB-1:0] out_d;
  logic [2:0] outstanding;
  int vectors = 0, miscompares = 0;
  int sb[$];
  logic exp_err = 1'b0;

  lib_rsp_router #(.NUM(NUM), .NUM_BITS(NB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_fire(req_fire), .req_gnt(req_gnt), .tag_rdy(tag_rdy),
    .err_gnt(err_gnt), .rsp_val(rsp_val), .rsp_d(rsp_d), .rsp_rdy(rsp_rdy), .out_val(out_val),
    .out_d(out_d), .out_rdy(out_rdy), .orphan(orphan), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update the model.
  task automatic step(input logic f, input logic [3:0] g, input logic rv, input logic [31:0] rd,
                      input logic [3:0] ordy);
    bit emp, do_pop, do_push;
    int head;
    req_fire = f; req_gnt = g; rsp_val = rv; rsp_d = rd; out_rdy = ordy;
    #1;
    emp = sb.size() == 0;
    head = emp ? 0 : sb[0];
    do_pop = rv && !emp && ordy[head];
    do_push = f && sb.size() < DEPTH && $onehot(g);
    chk("err_gnt", err_gnt, exp_err);
    chk("outstanding", outstanding, sb.size());
    chk("tag_rdy", tag_rdy, sb.size() < DEPTH);
    chk("rsp_rdy", rsp_rdy, !emp && ordy[head]);
    chk("out_val", out_val, (rv && !emp) ? (4'b1 << head) : 4'b0);
    chk("orphan", orphan, rv && emp);
    if (do_pop) chk($sformatf("out_d[%0d]", head), out_d[head*NB +: NB], rd);
    @(posedge clk);
    #1;
    exp_err = f && !$onehot(g);
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back(g[3] ? 3 : g[2] ? 2 : g[1] ? 1 : 0);
  endtask

  task automatic req(input logic [3:0] g);
    step(1'b1, g, 1'b0, '0, 4'hF);
  endtask

  task automatic rsp(input logic [31:0] d, input logic [3:0] ordy);
    step(1'b0, 4'h0, 1'b1, d, ordy);
  endtask

  initial begin
    #3;
    chk("rst_tag_rdy", tag_rdy, 1'b1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_rdy", rsp_rdy, 1'b0);
    chk("rst_err", err_gnt, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    // in-order steering
    req(4'b0100); req(4'b0001); req(4'b1000);
    rsp(32'hA, 4'hF); rsp(32'hB, 4'hF); rsp(32'hC, 4'hF);
    step(1'b0, 4'h0, 1'b0, '0, 4'hF);
    // backpressure on head lane 2
    req(4'b0100);
    rsp(32'h11, 4'b1011); rsp(32'h11, 4'b1011); rsp(32'h11, 4'b1111);
    // fill, ignored fifth, then wrap with pop/push pairs
    req(4'b0001); req(4'b0010); req(4'b0100); req(4'b1000); req(4'b0001);
    step(1'b1, 4'b0010, 1'b1, 32'h55, 4'hF);
    for (int i = 0; i < 6; i++) begin
      rsp($urandom, 4'hF);
      req(4'b1 << $urandom_range(0, 3));
    end
    while (sb.size() != 0) rsp($urandom, 4'hF);
    // simultaneous push/pop at occupancy 2
    req(4'b0010); req(4'b1000);
    step(1'b1, 4'b0001, 1'b1, 32'h77, 4'hF);
    chk("occ_pushpop", outstanding, 2);
    while (sb.size() != 0) rsp($urandom, 4'hF);
    // push and response together on an empty queue
    step(1'b1, 4'b0100, 1'b1, 32'h99, 4'hF);
    rsp(32'h99, 4'hF);
    // bad grant, then idle to see the pulse drop
    step(1'b1, 4'b0110, 1'b0, '0, 4'hF);
    step(1'b1, 4'b0000, 1'b0, '0, 4'hF);
    step(1'b0, 4'h0, 1'b0, '0, 4'hF);
    step(1'b0, 4'h0, 1'b0, '0, 4'hF);
    // async reset with 3 outstanding
    req(4'b0001); req(4'b0010); req(4'b0100);
    rsp_val = 1'b1; out_rdy = 4'hF;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_tag_rdy", tag_rdy, 1'b1);
    chk("mid_rst_rsp_rdy", rsp_rdy, 1'b0);
    chk("mid_rst_out_val", out_val, 4'b0);
    chk("mid_rst_orphan", orphan, 1'b1);
    sb.delete();
    exp_err = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rsp(32'hDEAD, 4'hF);
    step(1'b0, 4'h0, 1'b0, '0, 4'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
